// File: rtl/detect_sched_pkg.sv
// Shared types and helpers for the serial run-detection scheduler.
// Run counts are 2 bits and saturate at 3.
package detect_sched_pkg;

  typedef logic [1:0] run_t;

  localparam run_t RUN_SAT = 2'd3;

  // Channel-index width; never narrower than one bit.
  function automatic int ch_idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/detect_sched_if.sv
// Request/grant and detection bundle between requesters and detect_sched.
// Handshake: a bit on channel i is consumed at the posedge where req_valid[i] and req_ready[i] are both 1.
interface detect_sched_if
  import detect_sched_pkg::*;
#(
  parameter int NCH = 4
) ();

  logic [NCH-1:0]             req_valid;
  logic [NCH-1:0]             req_bit;
  logic [NCH-1:0]             chan_clr;
  logic [NCH-1:0]             req_ready;
  logic                       det_valid;
  logic [ch_idx_w(NCH)-1:0]   det_ch;
  run_t                       det_run;

  modport master (
    output req_valid, req_bit, chan_clr,
    input  req_ready, det_valid, det_ch, det_run
  );

  modport slave (
    input  req_valid, req_bit, chan_clr,
    output req_ready, det_valid, det_ch, det_run
  );

endinterface

// File: rtl/detect_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first eligible channel at or after ptr.
module rr_arbiter
  import detect_sched_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0]           eligible,
  input  logic [ch_idx_w(NCH)-1:0] ptr,
  output logic [NCH-1:0]           grant
);

  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!found && eligible[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/detect_sched.sv
// Shared run-detection engine: serves one serial requester per cycle and
// emits a registered pulse when a qualifying run of 1s is terminated by a 0.
module detect_sched
  import detect_sched_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int MIN_RUN = 1
) (
  input  logic         clk,
  input  logic         reset,
  detect_sched_if.slave bus
);

  localparam int W = ch_idx_w(NCH);

  logic [NCH-1:0] eligible;
  logic [NCH-1:0] grant;
  logic           g_any;
  int             g_idx;

  logic [W-1:0]   ptr_q, ptr_d;
  run_t           run_q [NCH];
  run_t           run_d [NCH];
  logic           det_valid_q, det_valid_d;
  logic [W-1:0]   det_ch_q, det_ch_d;
  run_t           det_run_q, det_run_d;

  // Reset gates eligibility so nothing is consumed while reset is held.
  assign eligible = bus.req_valid & ~bus.chan_clr & {NCH{reset}};

  rr_arbiter #(.NCH(NCH)) u_arb (
    .eligible (eligible),
    .ptr      (ptr_q),
    .grant    (grant)
  );

  assign bus.req_ready = grant;
  assign g_any         = |grant;

  always_comb begin
    g_idx = 0;
    for (int i = 0; i < NCH; i++) begin
      if (grant[i]) g_idx = i;
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    det_valid_d = 1'b0;
    det_ch_d    = det_ch_q;
    det_run_d   = det_run_q;
    for (int i = 0; i < NCH; i++) begin
      run_d[i] = bus.chan_clr[i] ? '0 : run_q[i];
    end
    if (g_any) begin
      ptr_d = (g_idx == NCH - 1) ? '0 : W'(g_idx + 1);
      if (bus.req_bit[g_idx]) begin
        run_d[g_idx] = (run_q[g_idx] == RUN_SAT) ? RUN_SAT : run_q[g_idx] + 2'd1;
      end else begin
        // Report the run length seen before the terminating 0.
        if (run_q[g_idx] >= run_t'(MIN_RUN)) begin
          det_valid_d = 1'b1;
          det_ch_d    = W'(g_idx);
          det_run_d   = run_q[g_idx];
        end
        run_d[g_idx] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q       <= '0;
      det_valid_q <= 1'b0;
      det_ch_q    <= '0;
      det_run_q   <= '0;
      for (int i = 0; i < NCH; i++) run_q[i] <= '0;
    end else begin
      ptr_q       <= ptr_d;
      det_valid_q <= det_valid_d;
      det_ch_q    <= det_ch_d;
      det_run_q   <= det_run_d;
      for (int i = 0; i < NCH; i++) run_q[i] <= run_d[i];
    end
  end

  assign bus.det_valid = det_valid_q;
  assign bus.det_ch    = det_ch_q;
  assign bus.det_run   = det_run_q;

endmodule

// File: tb/tb_detect_sched.sv
// Directed bench for detect_sched: MIN_RUN=1 and MIN_RUN=2 instances, 4 channels each.
module tb_detect_sched;

  logic clk;
  logic reset;

  int n_checks = 0;
  int n_errors = 0;

  // Expected detections on b0 as {det_ch, det_run}.
  logic [3:0] exp_q[$];

  detect_sched_if #(.NCH(4)) b0 ();
  detect_sched_if #(.NCH(4)) b1 ();

  detect_sched #(.NCH(4), .MIN_RUN(1)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (b0.slave)
  );

  detect_sched #(.NCH(4), .MIN_RUN(2)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1.slave)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic send0(input int ch, input logic b);
    logic [3:0] m;
    m            = 4'b0001 << ch;
    b0.req_valid = m;
    b0.req_bit   = b ? 4'hF : 4'h0;
    @(negedge clk);
    check("ready0", {28'd0, b0.req_ready}, {28'd0, m});
    @(posedge clk);
    #1;
    b0.req_valid = '0;
  endtask

  task automatic send1(input int ch, input logic b);
    logic [3:0] m;
    m            = 4'b0001 << ch;
    b1.req_valid = m;
    b1.req_bit   = b ? 4'hF : 4'h0;
    @(negedge clk);
    check("ready1", {28'd0, b1.req_ready}, {28'd0, m});
    @(posedge clk);
    #1;
    b1.req_valid = '0;
  endtask

  task automatic idle();
    b0.req_valid = '0;
    b1.req_valid = '0;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor for b0 detection pulses
  always @(negedge clk) begin
    if (b0.det_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("det_unexpected", 32'd1, 32'd0);
      end else begin
        check("det_pair", {28'd0, b0.det_ch, b0.det_run}, {28'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    reset        = 1'b0;
    b0.req_valid = 4'hF;
    b0.req_bit   = 4'h0;
    b0.chan_clr  = 4'h0;
    b1.req_valid = 4'hF;
    b1.req_bit   = 4'h0;
    b1.chan_clr  = 4'h0;

    // Reset state: no grants while held, detection outputs cleared
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_ready0", {28'd0, b0.req_ready}, 32'd0);
    check("rst_ready1", {28'd0, b1.req_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("rst_det_valid", {31'd0, b0.det_valid}, 32'd0);
    check("rst_det_ch", {30'd0, b0.det_ch}, 32'd0);
    check("rst_det_run", {30'd0, b0.det_run}, 32'd0);
    reset        = 1'b1;
    b0.req_valid = '0;
    b1.req_valid = '0;

    // MIN_RUN=2: single 1 then 0 is ignored; 1,1,0 reports run 2
    send1(2, 1'b1);
    check("mr2_a", {31'd0, b1.det_valid}, 32'd0);
    send1(2, 1'b0);
    check("mr2_short", {31'd0, b1.det_valid}, 32'd0);
    send1(2, 1'b1);
    send1(2, 1'b1);
    send1(2, 1'b0);
    check("mr2_det_valid", {31'd0, b1.det_valid}, 32'd1);
    check("mr2_det_ch", {30'd0, b1.det_ch}, 32'd2);
    check("mr2_det_run", {30'd0, b1.det_run}, 32'd2);
    idle();
    check("mr2_pulse_end", {31'd0, b1.det_valid}, 32'd0);

    // Channel 0: 1,0 gives a run-1 detection one cycle after the 0
    send0(0, 1'b1);
    check("c0_no_det", {31'd0, b0.det_valid}, 32'd0);
    exp_q.push_back({2'd0, 2'd1});
    send0(0, 1'b0);
    check("c0_det_valid", {31'd0, b0.det_valid}, 32'd1);
    check("c0_det_run", {30'd0, b0.det_run}, 32'd1);
    idle();
    check("c0_pulse_end", {31'd0, b0.det_valid}, 32'd0);
    check("c0_hold_run", {30'd0, b0.det_run}, 32'd1);

    // Channel 1: five 1s saturate at 3, then a single pulse
    for (int k = 0; k < 5; k++) begin
      send0(1, 1'b1);
      check("c1_no_det", {31'd0, b0.det_valid}, 32'd0);
    end
    exp_q.push_back({2'd1, 2'd3});
    send0(1, 1'b0);
    check("c1_det_valid", {31'd0, b0.det_valid}, 32'd1);
    check("c1_det_ch", {30'd0, b0.det_ch}, 32'd1);
    check("c1_det_run", {30'd0, b0.det_run}, 32'd3);
    idle();
    check("c1_pulse_end", {31'd0, b0.det_valid}, 32'd0);

    // Channel 3 cleared while presenting a 0; channel 2 keeps its run
    send0(3, 1'b1);
    send0(3, 1'b1);
    send0(2, 1'b1);
    b0.req_valid = 4'b1000;
    b0.req_bit   = 4'h0;
    b0.chan_clr  = 4'b1000;
    @(negedge clk);
    check("clr_ready", {28'd0, b0.req_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("clr_no_det", {31'd0, b0.det_valid}, 32'd0);
    b0.chan_clr  = 4'h0;
    b0.req_valid = '0;
    send0(3, 1'b0);
    check("clr_run_zero", {31'd0, b0.det_valid}, 32'd0);
    exp_q.push_back({2'd2, 2'd1});
    send0(2, 1'b0);
    check("clr_other_det", {31'd0, b0.det_valid}, 32'd1);
    check("clr_other_ch", {30'd0, b0.det_ch}, 32'd2);

    // Reset right after a qualifying 0: partial runs on ch1/ch2 are discarded
    send0(1, 1'b1);
    send0(2, 1'b1);
    send0(0, 1'b1);
    exp_q.push_back({2'd0, 2'd1});
    send0(0, 1'b0);
    check("pre_rst_det", {31'd0, b0.det_valid}, 32'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_det_valid", {31'd0, b0.det_valid}, 32'd0);
    check("mid_rst_det_run", {30'd0, b0.det_run}, 32'd0);
    reset = 1'b1;

    // All channels valid with 0 bits: grants rotate from ptr=0, no detections
    b0.req_valid = 4'hF;
    b0.req_bit   = 4'h0;
    for (int k = 0; k < 8; k++) begin
      logic [3:0] m;
      m = 4'b0001 << (k % 4);
      @(negedge clk);
      check("rr_grant", {28'd0, b0.req_ready}, {28'd0, m});
      @(posedge clk);
      #1;
      check("rr_no_det", {31'd0, b0.det_valid}, 32'd0);
    end
    b0.req_valid = '0;
    idle();
    idle();

    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/detect_sched.md
DETECT_SCHED -- requirements
Module: detect_sched

Interface
REQ-001 Parameter NCH, default 4, meaning number of serial bit-stream requesters; legal range 2..8.
REQ-002 Parameter MIN_RUN, default 1, meaning minimum run of consecutive 1s before a 0 counts as a detection; legal range 1..3.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-low reset; sampled only on posedge clk.
REQ-005 req_valid  input  NCH  per-channel request: a bit is presented.
REQ-006 req_bit  input  NCH  per-channel serial data bit, meaningful only when the matching req_valid is 1.
REQ-007 chan_clr  input  NCH  per-channel clear of the run state.
REQ-008 req_ready  output  NCH  one-hot grant; a bit is consumed when req_valid and req_ready are both 1.
REQ-009 det_valid  output  1  registered detection pulse.
REQ-010 det_ch  output  clog2(NCH)  channel that produced the detection.
REQ-011 det_run  output  2  run length (1..3, saturated) that preceded the terminating 0.

Function
REQ-012 Shared engine: the block SHALL keep a 2-bit run count per channel and serve at most one channel per cycle.
REQ-013 Arbitration SHALL be round-robin: the grant goes to the first channel, starting at pointer ptr and ascending modulo NCH, with req_valid=1 and chan_clr=0.
REQ-014 req_ready SHALL be combinational from req_valid, chan_clr and ptr, with at most one bit set, and all zero when no channel is eligible.
REQ-015 After a grant to channel g, ptr SHALL become (g+1) mod NCH; with no grant, ptr SHALL hold.
REQ-016 Granted bit=1: run[g] becomes min(run[g]+1, 3) (saturates at 3, no wrap).
REQ-017 Granted bit=0 with run[g] >= MIN_RUN: the next cycle SHALL show det_valid=1, det_ch=g and det_run=run[g] (pre-update value); run[g] becomes 0.
REQ-018 Granted bit=0 with run[g] < MIN_RUN: run[g] becomes 0 and det_valid is 0 next cycle.
REQ-019 det_valid SHALL be 0 in any cycle not following a qualifying grant; det_ch and det_run SHALL hold their last values when det_valid=0.
REQ-020 Latency from the accepting edge to det_valid SHALL be exactly 1 cycle; sustained throughput SHALL be 1 bit per cycle.
REQ-021 chan_clr[i]=1 SHALL set run[i] to 0 at the next edge and SHALL block a grant to i in that cycle; other channels are unaffected.
REQ-022 The run count of an ungranted channel SHALL hold.

Reset
REQ-023 With reset=0 at posedge clk: all run counts 0, ptr=0, det_valid=0, det_ch=0, det_run=0.
REQ-024 While reset=0, req_ready SHALL be all zero, so no bit is consumed.
REQ-025 Reset asserted mid-stream SHALL discard all partial runs; a detection registered in the same edge SHALL be suppressed (det_valid=0).

Structure
REQ-026 A shared package SHALL hold the run-count type (2-bit), the saturation constant 3, and the channel-index width function.
REQ-027 Arbitration SHALL live in one sub-module, rr_arbiter (inputs: eligible vector and ptr; output: one-hot grant). The run-state update and the detection register SHALL remain in detect_sched.

Verification
REQ-028 Channel 0 only, bits 1,0 with MIN_RUN=1 -> det_valid=1, det_ch=0, det_run=1 one cycle after the 0 is accepted.
REQ-029 Channel 1, bits 1,1,1,1,1,0 -> run saturates at 3; a single det_valid with det_run=3; no other pulses.
REQ-030 All four channels valid every cycle from reset -> grants go 0,1,2,3,0,... with exactly one req_ready bit per cycle.
REQ-031 MIN_RUN=2, channel 2 bits 1,0 then 1,1,0 -> no detection for the first 0; detection with det_run=2 for the second.
REQ-032 Channel 3 run=2, then chan_clr[3]=1 together with req_valid[3]=1 and bit 0 -> req_ready[3]=0, no detection, run[3]=0 afterwards.
REQ-033 reset=0 in the cycle after a qualifying 0 is accepted -> det_valid stays 0, ptr=0, and all runs restart from 0.
